// File: rtl/ysyx_24100012_lsu_pkg.sv
// Shared definitions for the sequential load/store unit: funct3 encodings,
// FSM state encoding and the access-size decode.
package ysyx_24100012_lsu_pkg;

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_D  = 3'b011;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;
    localparam logic [2:0] F3_WU = 3'b110;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        MREQ  = 2'd1,
        MWAIT = 2'd2,
        RESP  = 2'd3
    } lsu_state_e;

    // Byte count of an access; the unsigned variants share the low two bits.
    function automatic logic [3:0] size_bytes(input logic [2:0] funct3);
        case (funct3[1:0])
            2'b00:   return 4'd1;
            2'b01:   return 4'd2;
            2'b10:   return 4'd4;
            default: return 4'd8;
        endcase
    endfunction

endpackage

// File: rtl/ysyx_24100012_load_align.sv
// Combinational load-data alignment: selects the addressed field of an aligned
// bus word and sign- or zero-extends it according to funct3.
module ysyx_24100012_load_align
    import ysyx_24100012_lsu_pkg::*;
#(
    parameter int DATA_WIDTH = 32,
    localparam int OFF_W = $clog2(DATA_WIDTH / 8)
) (
    input  logic [DATA_WIDTH-1:0] mem_rdata,
    input  logic [OFF_W-1:0]      offset,
    input  logic [2:0]            funct3,
    output logic [DATA_WIDTH-1:0] result
);

    logic [DATA_WIDTH-1:0] shifted;

    always_comb begin
        shifted = mem_rdata >> {offset, 3'b000};
        result  = shifted;
        case (funct3)
            F3_B:    result = DATA_WIDTH'($signed(shifted[7:0]));
            F3_H:    result = DATA_WIDTH'($signed(shifted[15:0]));
            F3_W:    result = DATA_WIDTH'($signed(shifted[31:0]));
            F3_BU:   result = DATA_WIDTH'(shifted[7:0]);
            F3_HU:   result = DATA_WIDTH'(shifted[15:0]);
            F3_WU:   result = DATA_WIDTH'(shifted[31:0]);
            default: result = shifted;
        endcase
    end

endmodule

// File: rtl/ysyx_24100012_lsu_seq.sv
// Sequential load/store unit: one request at a time, lane-aligned memory
// transaction with byte strobes, registered extended response.
//
// state | meaning
// IDLE  | ready for a request; latch it and decode errors
// MREQ  | memory request held stable until mem_ready
// MWAIT | load issued, waiting for mem_rvalid
// RESP  | response held until resp_ready
module ysyx_24100012_lsu_seq
    import ysyx_24100012_lsu_pkg::*;
#(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32,
    localparam int STRB_WIDTH = DATA_WIDTH / 8
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic                  req_wen,
    input  logic [2:0]            req_funct3,
    input  logic [ADDR_WIDTH-1:0] req_addr,
    input  logic [DATA_WIDTH-1:0] req_wdata,
    output logic                  resp_valid,
    input  logic                  resp_ready,
    output logic [DATA_WIDTH-1:0] resp_rdata,
    output logic                  resp_misalign,
    output logic                  resp_illegal,
    output logic                  mem_valid,
    input  logic                  mem_ready,
    output logic                  mem_wen,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    output logic [STRB_WIDTH-1:0] mem_wstrb,
    output logic [DATA_WIDTH-1:0] mem_wdata,
    input  logic                  mem_rvalid,
    input  logic [DATA_WIDTH-1:0] mem_rdata
);

    localparam int OFF_W = $clog2(STRB_WIDTH);

    lsu_state_e            state, state_next;
    logic                  wen_q;
    logic [2:0]            funct3_q;
    logic [ADDR_WIDTH-1:0] addr_q;
    logic [DATA_WIDTH-1:0] wdata_q;
    logic [DATA_WIDTH-1:0] rdata_q;
    logic                  misalign_q;
    logic                  illegal_q;

    logic                  req_illegal;
    logic                  req_misalign;
    logic                  accept;
    logic [OFF_W-1:0]      offset;
    logic [STRB_WIDTH-1:0] lane_mask;
    logic [DATA_WIDTH-1:0] load_data;

    assign accept = (state == IDLE) && req_valid;
    assign offset = addr_q[OFF_W-1:0];

    always_comb begin
        req_illegal = (req_funct3 == 3'b111)
                   || (req_wen && req_funct3[2])
                   || ((DATA_WIDTH == 32) && ((req_funct3 == F3_D) || (req_funct3 == F3_WU)));
        req_misalign = 1'b0;
        case (req_funct3[1:0])
            2'b01:   req_misalign = req_addr[0];
            2'b10:   req_misalign = |req_addr[1:0];
            2'b11:   req_misalign = |req_addr[2:0];
            default: req_misalign = 1'b0;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE: begin
                if (req_valid) begin
                    state_next = (req_illegal || req_misalign) ? RESP : MREQ;
                end
            end
            MREQ: begin
                if (mem_ready) begin
                    state_next = wen_q ? RESP : MWAIT;
                end
            end
            MWAIT: begin
                if (mem_rvalid) begin
                    state_next = RESP;
                end
            end
            RESP: begin
                if (resp_ready) begin
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wen_q      <= 1'b0;
            funct3_q   <= 3'b000;
            addr_q     <= '0;
            wdata_q    <= '0;
            rdata_q    <= '0;
            misalign_q <= 1'b0;
            illegal_q  <= 1'b0;
        end else if (accept) begin
            wen_q      <= req_wen;
            funct3_q   <= req_funct3;
            addr_q     <= req_addr;
            wdata_q    <= req_wdata;
            rdata_q    <= '0;
            // Illegal takes precedence so only one error flag is ever reported.
            misalign_q <= req_misalign && !req_illegal;
            illegal_q  <= req_illegal;
        end else if ((state == MWAIT) && mem_rvalid) begin
            rdata_q    <= load_data;
        end
    end

    ysyx_24100012_load_align #(
        .DATA_WIDTH(DATA_WIDTH)
    ) u_load_align (
        .mem_rdata(mem_rdata),
        .offset   (offset),
        .funct3   (funct3_q),
        .result   (load_data)
    );

    always_comb begin
        lane_mask = STRB_WIDTH'((16'd1 << size_bytes(funct3_q)) - 16'd1);
    end

    assign req_ready     = (state == IDLE);
    assign mem_valid     = (state == MREQ);
    assign mem_wen       = wen_q;
    assign mem_addr      = {addr_q[ADDR_WIDTH-1:OFF_W], {OFF_W{1'b0}}};
    assign mem_wstrb     = wen_q ? (lane_mask << offset) : '0;
    assign mem_wdata     = wdata_q << {offset, 3'b000};
    assign resp_valid    = (state == RESP);
    assign resp_rdata    = rdata_q;
    assign resp_misalign = misalign_q;
    assign resp_illegal  = illegal_q;

endmodule

// File: tb/tb_ysyx_24100012_lsu_seq.sv
// Directed bench for the sequential LSU: 32-bit and 64-bit instances, responses
// checked against a scoreboard of expected results pushed at request time.
module tb_ysyx_24100012_lsu_seq;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    logic        req_valid, req_ready, req_wen;
    logic [2:0]  req_funct3;
    logic [31:0] req_addr, req_wdata;
    logic        resp_valid, resp_ready, resp_misalign, resp_illegal;
    logic [31:0] resp_rdata;
    logic        mem_valid, mem_ready, mem_wen, mem_rvalid;
    logic [31:0] mem_addr, mem_wdata, mem_rdata;
    logic [3:0]  mem_wstrb;

    logic        d_req_valid, d_req_ready, d_req_wen;
    logic [2:0]  d_req_funct3;
    logic [31:0] d_req_addr;
    logic [63:0] d_req_wdata;
    logic        d_resp_valid, d_resp_ready, d_resp_misalign, d_resp_illegal;
    logic [63:0] d_resp_rdata;
    logic        d_mem_valid, d_mem_ready, d_mem_wen, d_mem_rvalid;
    logic [31:0] d_mem_addr;
    logic [63:0] d_mem_wdata, d_mem_rdata;
    logic [7:0]  d_mem_wstrb;

    ysyx_24100012_lsu_seq #(.ADDR_WIDTH(32), .DATA_WIDTH(32)) u_dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_ready(req_ready), .req_wen(req_wen),
        .req_funct3(req_funct3), .req_addr(req_addr), .req_wdata(req_wdata),
        .resp_valid(resp_valid), .resp_ready(resp_ready), .resp_rdata(resp_rdata),
        .resp_misalign(resp_misalign), .resp_illegal(resp_illegal),
        .mem_valid(mem_valid), .mem_ready(mem_ready), .mem_wen(mem_wen),
        .mem_addr(mem_addr), .mem_wstrb(mem_wstrb), .mem_wdata(mem_wdata),
        .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata)
    );

    ysyx_24100012_lsu_seq #(.ADDR_WIDTH(32), .DATA_WIDTH(64)) u_dut64 (
        .clk(clk), .rst(rst),
        .req_valid(d_req_valid), .req_ready(d_req_ready), .req_wen(d_req_wen),
        .req_funct3(d_req_funct3), .req_addr(d_req_addr), .req_wdata(d_req_wdata),
        .resp_valid(d_resp_valid), .resp_ready(d_resp_ready), .resp_rdata(d_resp_rdata),
        .resp_misalign(d_resp_misalign), .resp_illegal(d_resp_illegal),
        .mem_valid(d_mem_valid), .mem_ready(d_mem_ready), .mem_wen(d_mem_wen),
        .mem_addr(d_mem_addr), .mem_wstrb(d_mem_wstrb), .mem_wdata(d_mem_wdata),
        .mem_rvalid(d_mem_rvalid), .mem_rdata(d_mem_rdata)
    );

    typedef struct {
        logic [63:0] rdata;
        logic        mis;
        logic        ill;
    } exp_t;

    exp_t sb32[$];
    exp_t sb64[$];
    exp_t e32, e64;
    int   checks = 0;
    int   errors = 0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    always @(negedge clk) begin
        if (rst && resp_valid && resp_ready) begin
            if (sb32.size() == 0) begin
                checks++;
                errors++;
                $error("FAIL resp32_spurious: observed response %0h expected none", resp_rdata);
            end else begin
                e32 = sb32.pop_front();
                chk("resp32_rdata", 64'(resp_rdata), e32.rdata);
                chk("resp32_misalign", 64'(resp_misalign), 64'(e32.mis));
                chk("resp32_illegal", 64'(resp_illegal), 64'(e32.ill));
            end
        end
        if (rst && d_resp_valid && d_resp_ready) begin
            if (sb64.size() == 0) begin
                checks++;
                errors++;
                $error("FAIL resp64_spurious: observed response %0h expected none", d_resp_rdata);
            end else begin
                e64 = sb64.pop_front();
                chk("resp64_rdata", d_resp_rdata, e64.rdata);
                chk("resp64_misalign", 64'(d_resp_misalign), 64'(e64.mis));
                chk("resp64_illegal", 64'(d_resp_illegal), 64'(e64.ill));
            end
        end
    end

    // Zero-wait load: mem_valid in cycle 1, response in cycle 3.
    task automatic load_zw(input logic [2:0] f3, input logic [31:0] addr,
                           input logic [31:0] rd, input logic [31:0] exp, input string tag);
        req_valid = 1'b1; req_wen = 1'b0; req_funct3 = f3; req_addr = addr;
        req_wdata = $urandom; mem_ready = 1'b1; mem_rvalid = 1'b1; mem_rdata = rd;
        resp_ready = 1'b1;
        sb32.push_back('{rdata: 64'(exp), mis: 1'b0, ill: 1'b0});
        chk({tag, "_req_ready"}, 64'(req_ready), 64'd1);
        tick();
        req_valid = 1'b0;
        chk({tag, "_mem_valid"}, 64'(mem_valid), 64'd1);
        chk({tag, "_mem_addr"}, 64'(mem_addr), 64'({addr[31:2], 2'b00}));
        chk({tag, "_mem_wstrb"}, 64'(mem_wstrb), 64'd0);
        tick();
        chk({tag, "_c2_resp_valid"}, 64'(resp_valid), 64'd0);
        tick();
        chk({tag, "_c3_resp_valid"}, 64'(resp_valid), 64'd1);
        tick();
        mem_ready = 1'b0; mem_rvalid = 1'b0;
        chk({tag, "_back_idle"}, 64'(req_ready), 64'd1);
    endtask

    // Zero-wait store: response in cycle 2.
    task automatic store_zw(input logic [2:0] f3, input logic [31:0] addr, input logic [31:0] wd,
                            input logic [3:0] strb, input logic [31:0] lane, input string tag);
        req_valid = 1'b1; req_wen = 1'b1; req_funct3 = f3; req_addr = addr; req_wdata = wd;
        mem_ready = 1'b1; mem_rvalid = 1'b0; resp_ready = 1'b1;
        sb32.push_back('{rdata: 64'd0, mis: 1'b0, ill: 1'b0});
        tick();
        req_valid = 1'b0;
        chk({tag, "_mem_valid"}, 64'(mem_valid), 64'd1);
        chk({tag, "_mem_wen"}, 64'(mem_wen), 64'd1);
        chk({tag, "_mem_wstrb"}, 64'(mem_wstrb), 64'(strb));
        chk({tag, "_mem_wdata"}, 64'(mem_wdata), 64'(lane));
        tick();
        chk({tag, "_c2_resp_valid"}, 64'(resp_valid), 64'd1);
        tick();
        mem_ready = 1'b0;
    endtask

    // Error request: response in cycle 1, memory never touched.
    task automatic err_req(input logic wen, input logic [2:0] f3, input logic [31:0] addr,
                           input logic mis, input logic ill, input string tag);
        req_valid = 1'b1; req_wen = wen; req_funct3 = f3; req_addr = addr;
        req_wdata = $urandom; mem_ready = 1'b1; mem_rvalid = 1'b1; resp_ready = 1'b1;
        sb32.push_back('{rdata: 64'd0, mis: mis, ill: ill});
        tick();
        req_valid = 1'b0;
        chk({tag, "_mem_valid"}, 64'(mem_valid), 64'd0);
        chk({tag, "_c1_resp_valid"}, 64'(resp_valid), 64'd1);
        tick();
        mem_ready = 1'b0; mem_rvalid = 1'b0;
        chk({tag, "_back_idle"}, 64'(req_ready), 64'd1);
    endtask

    logic [2:0]  t64_f3   [4] = '{3'b110, 3'b010, 3'b011, 3'b011};
    logic [31:0] t64_addr [4] = '{32'h4, 32'h4, 32'h8, 32'h4};
    logic [63:0] t64_rd   [4] = '{64'h9ABC_DEF0_0000_0000, 64'h9ABC_DEF0_0000_0000,
                                  64'h0123_4567_89AB_CDEF, 64'h0};
    logic [63:0] t64_exp  [4] = '{64'h0000_0000_9ABC_DEF0, 64'hFFFF_FFFF_9ABC_DEF0,
                                  64'h0123_4567_89AB_CDEF, 64'h0};
    logic        t64_mis  [4] = '{1'b0, 1'b0, 1'b0, 1'b1};

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish within time limit");
        $fatal(1, "timeout");
    end

    initial begin
        rst = 1'b0;
        req_valid = 0; req_wen = 0; req_funct3 = 0; req_addr = 0; req_wdata = 0;
        resp_ready = 0; mem_ready = 0; mem_rvalid = 0; mem_rdata = 0;
        d_req_valid = 0; d_req_wen = 0; d_req_funct3 = 0; d_req_addr = 0; d_req_wdata = 0;
        d_resp_ready = 0; d_mem_ready = 0; d_mem_rvalid = 0; d_mem_rdata = 0;
        tick();
        chk("rst_req_ready", 64'(req_ready), 64'd1);
        chk("rst_mem_valid", 64'(mem_valid), 64'd0);
        chk("rst_resp_valid", 64'(resp_valid), 64'd0);
        chk("rst_resp_rdata", 64'(resp_rdata), 64'd0);
        chk("rst_flags", 64'({resp_misalign, resp_illegal}), 64'd0);
        chk("rst_mem_addr", 64'(mem_addr), 64'd0);
        rst = 1'b1;
        tick();

        load_zw(3'b000, 32'h103, 32'h80FF_1234, 32'hFFFF_FF80, "lb");
        load_zw(3'b100, 32'h103, 32'h80FF_1234, 32'h0000_0080, "lbu");
        load_zw(3'b001, 32'h102, 32'h8001_0000, 32'hFFFF_8001, "lh");
        load_zw(3'b101, 32'h100, 32'h1234_ABCD, 32'h0000_ABCD, "lhu");
        err_req(1'b0, 3'b001, 32'h101, 1'b1, 1'b0, "lh_mis");

        // SB with mem_ready stalled three cycles.
        req_valid = 1'b1; req_wen = 1'b1; req_funct3 = 3'b000; req_addr = 32'h202;
        req_wdata = 32'h0000_00AB; mem_ready = 1'b0; resp_ready = 1'b1;
        sb32.push_back('{rdata: 64'd0, mis: 1'b0, ill: 1'b0});
        tick();
        req_valid = 1'b0; req_wdata = 32'hFFFF_FFFF; req_addr = 32'h0;
        for (int i = 0; i < 4; i++) begin
            if (i == 3) mem_ready = 1'b1;
            chk("sb_mem_valid", 64'(mem_valid), 64'd1);
            chk("sb_mem_addr", 64'(mem_addr), 64'h200);
            chk("sb_mem_wstrb", 64'(mem_wstrb), 64'h4);
            chk("sb_mem_wdata", 64'(mem_wdata), 64'h00AB_0000);
            chk("sb_resp_valid_stall", 64'(resp_valid), 64'd0);
            tick();
        end
        mem_ready = 1'b0;
        chk("sb_resp_valid", 64'(resp_valid), 64'd1);
        chk("sb_mem_valid_done", 64'(mem_valid), 64'd0);
        tick();

        store_zw(3'b001, 32'h102, 32'h0000_1234, 4'b1100, 32'h1234_0000, "sh");
        store_zw(3'b010, 32'h200, 32'hDEAD_BEEF, 4'b1111, 32'hDEAD_BEEF, "sw");

        // LW with rvalid delayed and resp_ready held low.
        req_valid = 1'b1; req_wen = 1'b0; req_funct3 = 3'b010; req_addr = 32'h300;
        mem_ready = 1'b1; mem_rvalid = 1'b0; resp_ready = 1'b0;
        sb32.push_back('{rdata: 64'h1234_5678, mis: 1'b0, ill: 1'b0});
        tick();
        req_valid = 1'b0;
        tick();
        mem_ready = 1'b0;
        for (int i = 0; i < 5; i++) begin
            chk("lw_wait_resp_valid", 64'(resp_valid), 64'd0);
            chk("lw_wait_req_ready", 64'(req_ready), 64'd0);
            tick();
        end
        mem_rvalid = 1'b1; mem_rdata = 32'h1234_5678;
        tick();
        mem_rvalid = 1'b0; mem_rdata = 32'h5555_AAAA;
        for (int i = 0; i < 2; i++) begin
            chk("lw_hold_resp_valid", 64'(resp_valid), 64'd1);
            chk("lw_hold_rdata", 64'(resp_rdata), 64'h1234_5678);
            chk("lw_hold_req_ready", 64'(req_ready), 64'd0);
            tick();
        end
        resp_ready = 1'b1;
        tick();
        chk("lw_after_resp_valid", 64'(resp_valid), 64'd0);
        chk("lw_after_req_ready", 64'(req_ready), 64'd1);

        err_req(1'b0, 3'b011, 32'h100, 1'b0, 1'b1, "ld32_ill");
        err_req(1'b0, 3'b110, 32'h100, 1'b0, 1'b1, "lwu32_ill");
        err_req(1'b0, 3'b111, 32'h100, 1'b0, 1'b1, "f3_111_ill");
        err_req(1'b1, 3'b100, 32'h100, 1'b0, 1'b1, "store_1xx_ill");
        err_req(1'b0, 3'b011, 32'h101, 1'b0, 1'b1, "ill_over_mis");
        err_req(1'b0, 3'b010, 32'h102, 1'b1, 1'b0, "lw_mis");
        err_req(1'b1, 3'b010, 32'h101, 1'b1, 1'b0, "sw_mis");

        // Reset while in MWAIT; late rvalid must be ignored.
        req_valid = 1'b1; req_wen = 1'b0; req_funct3 = 3'b010; req_addr = 32'h400;
        mem_ready = 1'b1; mem_rvalid = 1'b0; resp_ready = 1'b1;
        tick();
        req_valid = 1'b0;
        tick();
        chk("mrst_in_mwait", 64'({mem_valid, resp_valid, req_ready}), 64'd0);
        rst = 1'b0; mem_ready = 1'b0;
        tick();
        chk("mrst_req_ready", 64'(req_ready), 64'd1);
        chk("mrst_mem_valid", 64'(mem_valid), 64'd0);
        chk("mrst_resp", 64'({resp_valid, resp_misalign, resp_illegal}), 64'd0);
        chk("mrst_mem_addr", 64'(mem_addr), 64'd0);
        rst = 1'b1; mem_rvalid = 1'b1; mem_rdata = 32'hCAFE_F00D;
        for (int i = 0; i < 3; i++) begin
            chk("mrst_late_rvalid", 64'(resp_valid), 64'd0);
            chk("mrst_idle", 64'(req_ready), 64'd1);
            tick();
        end
        mem_rvalid = 1'b0;
        load_zw(3'b000, 32'h101, 32'h0000_7F00, 32'h0000_007F, "post_rst_lb");

        // 64-bit instance.
        for (int i = 0; i < 4; i++) begin
            d_req_valid = 1'b1; d_req_wen = 1'b0; d_req_funct3 = t64_f3[i];
            d_req_addr = t64_addr[i]; d_mem_ready = 1'b1; d_mem_rvalid = 1'b1;
            d_mem_rdata = t64_rd[i]; d_resp_ready = 1'b1;
            sb64.push_back('{rdata: t64_mis[i] ? 64'd0 : t64_exp[i], mis: t64_mis[i], ill: 1'b0});
            tick();
            d_req_valid = 1'b0;
            chk("d64_mem_valid", 64'(d_mem_valid), 64'(!t64_mis[i]));
            if (!t64_mis[i]) begin
                chk("d64_mem_addr", 64'(d_mem_addr), 64'({t64_addr[i][31:3], 3'b000}));
                tick();
                tick();
            end
            chk("d64_resp_valid", 64'(d_resp_valid), 64'd1);
            tick();
        end
        d_req_valid = 1'b1; d_req_wen = 1'b1; d_req_funct3 = 3'b010; d_req_addr = 32'h4;
        d_req_wdata = 64'h0000_0000_1122_3344; d_mem_rvalid = 1'b0;
        sb64.push_back('{rdata: 64'd0, mis: 1'b0, ill: 1'b0});
        tick();
        d_req_valid = 1'b0;
        chk("d64_sw_wstrb", 64'(d_mem_wstrb), 64'hF0);
        chk("d64_sw_wdata", d_mem_wdata, 64'h1122_3344_0000_0000);
        tick();
        chk("d64_sw_resp_valid", 64'(d_resp_valid), 64'd1);
        tick();
        d_mem_ready = 1'b0;

        repeat (2) tick();
        chk("sb32_drained", 64'(sb32.size()), 64'd0);
        chk("sb64_drained", 64'(sb64.size()), 64'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
